ad9945_serial_cfg: RTL

- Configuration sequencer for the AD9945 analog front end on the TCD1290D CCD board.
- Drives the AD9945 3-wire serial port (SL, SCK, SDATA).
- After reset release it autonomously writes the register init table: operation, control, clamp level, VGA gain.
- It then accepts single-register host writes through a req/ack handshake and supports re-running the init table on request.
- New frames start only while the line-timing logic signals it is safe (hold low).

---
 rtl/ad9945_pkg.sv | 30 +++
 rtl/ad9945_spi_shift.sv | 138 +++++++++++++
 rtl/ad9945_serial_cfg.sv | 151 +++++++++++++++
 3 files changed

// File: rtl/ad9945_pkg.sv
// Shared constants and state encodings for the AD9945 serial configuration slice.
package ad9945_pkg;

    // AD9945 register map entries written by the init table
    localparam int unsigned ADDR_OPER  = 0;
    localparam int unsigned ADDR_CTRL  = 1;
    localparam int unsigned ADDR_CLAMP = 2;
    localparam int unsigned ADDR_VGA   = 3;

    // Number of entries in the init table
    localparam int unsigned INIT_LEN = 4;

    // Sequencer states (top level)
    typedef enum logic [1:0] {
        SEQ_INIT_ARM,
        SEQ_IDLE,
        SEQ_FRAME
    } seq_state_t;

    // Serial frame phases (shifter)
    typedef enum logic [2:0] {
        PH_IDLE,
        PH_SETUP,
        PH_SHIFT_HI,
        PH_SHIFT_LO,
        PH_LAST,
        PH_GAP
    } phase_t;

endpackage

// File: rtl/ad9945_spi_shift.sv
// Frame shifter for the AD9945 3-wire port: H divider, bit counter and
// registered SL/SCK/SDATA generation. One frame per start pulse; done marks
// the final cycle of the gap phase.
module ad9945_spi_shift
    import ad9945_pkg::*;
#(
    parameter int unsigned N       = 15,
    parameter int unsigned CLK_DIV = 4
) (
    input  logic         sys_clk,
    input  logic         rst,
    input  logic         start,
    input  logic [N-1:0] word,
    output logic         busy,
    output logic         done,
    output logic         SL,
    output logic         SCK,
    output logic         SDATA
);

    localparam int unsigned BW = $clog2(N + 1);
    localparam logic [7:0] H_RELOAD = 8'(CLK_DIV - 1);

    phase_t         phase, phase_n;
    logic [7:0]     hcnt, hcnt_n;
    logic [BW-1:0]  bitcnt, bitcnt_n;
    logic [N-1:0]   shreg, shreg_n;
    logic           sl_n, sck_n, sd_n, busy_n;

    // Phase register and registered serial outputs
    always_ff @(posedge sys_clk or posedge rst) begin
        if (rst) begin
            phase  <= PH_IDLE;
            hcnt   <= '0;
            bitcnt <= '0;
            shreg  <= '0;
            SL     <= 1'b1;
            SCK    <= 1'b0;
            SDATA  <= 1'b0;
            busy   <= 1'b0;
        end else begin
            phase  <= phase_n;
            hcnt   <= hcnt_n;
            bitcnt <= bitcnt_n;
            shreg  <= shreg_n;
            SL     <= sl_n;
            SCK    <= sck_n;
            SDATA  <= sd_n;
            busy   <= busy_n;
        end
    end

    // Next phase, divider reload and next output levels
    always_comb begin
        phase_n  = phase;
        hcnt_n   = hcnt;
        bitcnt_n = bitcnt;
        shreg_n  = shreg;
        sl_n     = SL;
        sck_n    = SCK;
        sd_n     = SDATA;
        busy_n   = busy;
        done     = 1'b0;

        unique case (phase)
            PH_IDLE: begin
                if (start) begin
                    phase_n  = PH_SETUP;
                    hcnt_n   = H_RELOAD;
                    bitcnt_n = '0;
                    shreg_n  = word;
                    sl_n     = 1'b0;
                    sck_n    = 1'b0;
                    sd_n     = word[0];
                    busy_n   = 1'b1;
                end
            end
            PH_SETUP: begin
                if (hcnt == '0) begin
                    phase_n = PH_SHIFT_HI;
                    hcnt_n  = H_RELOAD;
                    sck_n   = 1'b1;
                end else begin
                    hcnt_n = hcnt - 8'd1;
                end
            end
            PH_SHIFT_HI: begin
                if (hcnt == '0) begin
                    hcnt_n = H_RELOAD;
                    sck_n  = 1'b0;
                    if (bitcnt == BW'(N - 1)) begin
                        phase_n = PH_LAST;
                    end else begin
                        // next bit goes out on the same edge SCK falls
                        phase_n  = PH_SHIFT_LO;
                        bitcnt_n = bitcnt + 1'b1;
                        shreg_n  = shreg >> 1;
                        sd_n     = shreg[1];
                    end
                end else begin
                    hcnt_n = hcnt - 8'd1;
                end
            end
            PH_SHIFT_LO: begin
                if (hcnt == '0) begin
                    phase_n = PH_SHIFT_HI;
                    hcnt_n  = H_RELOAD;
                    sck_n   = 1'b1;
                end else begin
                    hcnt_n = hcnt - 8'd1;
                end
            end
            PH_LAST: begin
                if (hcnt == '0) begin
                    phase_n = PH_GAP;
                    hcnt_n  = H_RELOAD;
                    sl_n    = 1'b1;
                    sd_n    = 1'b0;
                end else begin
                    hcnt_n = hcnt - 8'd1;
                end
            end
            PH_GAP: begin
                if (hcnt == '0) begin
                    phase_n = PH_IDLE;
                    busy_n  = 1'b0;
                    done    = 1'b1;
                end else begin
                    hcnt_n = hcnt - 8'd1;
                end
            end
            default: begin
                phase_n = PH_IDLE;
            end
        endcase
    end

endmodule

// File: rtl/ad9945_serial_cfg.sv
// AD9945 configuration sequencer: runs the four-entry init table after reset
// or on init_req, then services single-register host writes. Frames only
// start while hold is low; init always has priority over host writes.
module ad9945_serial_cfg
    import ad9945_pkg::*;
#(
    parameter int unsigned        ADDR_W    = 3,
    parameter int unsigned        DATA_W    = 12,
    parameter int unsigned        CLK_DIV   = 4,
    parameter logic [DATA_W-1:0]  OPER_INIT = '0,
    parameter logic [DATA_W-1:0]  CTRL_INIT = '0
) (
    input  logic              sys_clk,
    input  logic              rst,
    input  logic              init_req,
    input  logic [7:0]        clamp_level,
    input  logic [9:0]        vga_gain,
    input  logic              hold,
    input  logic              wr_req,
    input  logic [ADDR_W-1:0] wr_addr,
    input  logic [DATA_W-1:0] wr_data,
    output logic              wr_ack,
    output logic              busy,
    output logic              init_done,
    output logic              SL,
    output logic              SCK,
    output logic              SDATA
);

    localparam int unsigned N = ADDR_W + DATA_W;

    seq_state_t        state, state_n;
    logic [1:0]        idx, idx_n;
    logic              pending, pending_n;
    logic              frame_init, frame_init_n;
    logic              init_done_n, wr_ack_n;
    logic              start, done;
    logic [N-1:0]      word;
    logic [ADDR_W-1:0] tbl_addr;
    logic [DATA_W-1:0] tbl_data;

    // Init table lookup; clamp/VGA are sampled live so the frame start captures them
    always_comb begin
        tbl_addr = ADDR_W'(ADDR_OPER);
        tbl_data = OPER_INIT;
        unique case (idx)
            2'd0: begin tbl_addr = ADDR_W'(ADDR_OPER);  tbl_data = OPER_INIT;            end
            2'd1: begin tbl_addr = ADDR_W'(ADDR_CTRL);  tbl_data = CTRL_INIT;            end
            2'd2: begin tbl_addr = ADDR_W'(ADDR_CLAMP); tbl_data = DATA_W'(clamp_level); end
            2'd3: begin tbl_addr = ADDR_W'(ADDR_VGA);   tbl_data = DATA_W'(vga_gain);    end
            default: ;
        endcase
    end

    // Sequencer state and registered handshake outputs
    always_ff @(posedge sys_clk or posedge rst) begin
        if (rst) begin
            state      <= SEQ_INIT_ARM;
            idx        <= '0;
            pending    <= 1'b0;
            frame_init <= 1'b0;
            init_done  <= 1'b0;
            wr_ack     <= 1'b0;
        end else begin
            state      <= state_n;
            idx        <= idx_n;
            pending    <= pending_n;
            frame_init <= frame_init_n;
            init_done  <= init_done_n;
            wr_ack     <= wr_ack_n;
        end
    end

    // Arbitration between init table and host writes
    always_comb begin
        state_n      = state;
        idx_n        = idx;
        pending_n    = pending | init_req;
        frame_init_n = frame_init;
        init_done_n  = init_done & ~init_req;
        wr_ack_n     = 1'b0;
        start        = 1'b0;
        word         = {tbl_data, tbl_addr};

        unique case (state)
            SEQ_INIT_ARM: begin
                // a restart request seen while armed rewinds before any frame goes out
                if (pending) begin
                    idx_n     = '0;
                    pending_n = init_req;
                end else if (!hold) begin
                    start        = 1'b1;
                    frame_init_n = 1'b1;
                    state_n      = SEQ_FRAME;
                end
            end
            SEQ_IDLE: begin
                if (pending && !hold) begin
                    idx_n     = '0;
                    pending_n = init_req;
                    state_n   = SEQ_INIT_ARM;
                end else if (wr_req && !hold && !pending && !init_req) begin
                    start        = 1'b1;
                    word         = {wr_data, wr_addr};
                    wr_ack_n     = 1'b1;
                    frame_init_n = 1'b0;
                    state_n      = SEQ_FRAME;
                end
            end
            SEQ_FRAME: begin
                if (done) begin
                    if (pending) begin
                        idx_n     = '0;
                        pending_n = init_req;
                        state_n   = SEQ_INIT_ARM;
                    end else if (frame_init) begin
                        if (idx == 2'(INIT_LEN - 1)) begin
                            idx_n       = '0;
                            init_done_n = ~init_req;
                            state_n     = SEQ_IDLE;
                        end else begin
                            idx_n   = idx + 2'd1;
                            state_n = SEQ_INIT_ARM;
                        end
                    end else begin
                        state_n = SEQ_IDLE;
                    end
                end
            end
            default: begin
                state_n = SEQ_INIT_ARM;
            end
        endcase
    end

    ad9945_spi_shift #(
        .N       (N),
        .CLK_DIV (CLK_DIV)
    ) u_shift (
        .sys_clk (sys_clk),
        .rst     (rst),
        .start   (start),
        .word    (word),
        .busy    (busy),
        .done    (done),
        .SL      (SL),
        .SCK     (SCK),
        .SDATA   (SDATA)
    );

endmodule
